// File: rtl/datapath_mult.sv
// Shift-and-add multiplier datapath: M, A, Q and C registers plus latched product.
// Optional protocol checker (proto_err port) enabled by defining MULT_PROTO_CHECK_EN.
module datapath_mult #(
   parameter int WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 CargaQ,
   input  logic                 ResetA,
   input  logic                 CargaA,
   input  logic                 DesplazaQ,
   input  logic                 Fin,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 q0,
   output logic [2*WIDTH-1:0]   product,
   output logic                 product_valid
`ifdef MULT_PROTO_CHECK_EN
   ,
   output logic                 proto_err
`endif
);

   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] q_r;
   logic             c_r;
   logic [WIDTH:0]   sum_s;
   logic             shift_s;

   // Add is formed one bit wider so the carry-out lands in C untruncated.
   always_comb begin
      sum_s   = {1'b0, a_r} + {1'b0, m_r};
      shift_s = DesplazaQ & ~ResetA & ~CargaA;
   end

   assign q0 = q_r[0];

   // Multiplicand register: loaded only by CargaQ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_r <= {WIDTH{1'b0}};
      end else if (CargaQ) begin
         m_r <= multiplicand;
      end else begin
         m_r <= m_r;
      end
   end

   // Accumulator and carry: clear beats add, add beats shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r <= {WIDTH{1'b0}};
         c_r <= 1'b0;
      end else if (ResetA) begin
         a_r <= {WIDTH{1'b0}};
         c_r <= 1'b0;
      end else if (CargaA) begin
         {c_r, a_r} <= sum_s;
      end else if (DesplazaQ) begin
         a_r <= {c_r, a_r[WIDTH-1:1]};
         c_r <= 1'b0;
      end else begin
         a_r <= a_r;
         c_r <= c_r;
      end
   end

   // Multiplier / low-product register: load beats shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r <= {WIDTH{1'b0}};
      end else if (CargaQ) begin
         q_r <= multiplier;
      end else if (shift_s) begin
         q_r <= {a_r[0], q_r[WIDTH-1:1]};
      end else begin
         q_r <= q_r;
      end
   end

   // Product capture happens once per run; a new load only drops the valid flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         product       <= {(2*WIDTH){1'b0}};
         product_valid <= 1'b0;
      end else if (CargaQ) begin
         product       <= product;
         product_valid <= 1'b0;
      end else if (Fin && !product_valid) begin
         product       <= {a_r, q_r};
         product_valid <= 1'b1;
      end else begin
         product       <= product;
         product_valid <= product_valid;
      end
   end

`ifdef MULT_PROTO_CHECK_EN
   logic viol_s;

   // Illegal strobe combinations from the control unit.
   always_comb begin
      viol_s = (CargaA & DesplazaQ) | (CargaA & ResetA) |
               ((CargaA | DesplazaQ) & product_valid);
   end

   // Sticky error flag, cleared by reset or a fresh load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         proto_err <= 1'b0;
      end else if (CargaQ) begin
         proto_err <= 1'b0;
      end else if (viol_s) begin
         proto_err <= 1'b1;
      end else begin
         proto_err <= proto_err;
      end
   end
`endif

endmodule
